// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Owner index is a fixed 3 bits so NREQ up to 8 fits without resizing ports.
  localparam int OWNER_W = 3;

  // Bits needed to hold a burst count in 0..maxburst (ceil(log2(maxburst+1))).
  function automatic int cnt_width(input int maxburst);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= maxburst) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin winner search: first set req at or above ptr, wrapping at NREQ.
// Latency: purely combinational.
// Backpressure: none; consumer decides when the winner is taken.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  output logic               any,
  output logic [OWNER_W-1:0] winner
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] masked;
  logic              found;

  // Double the request vector, mask off everything below ptr in the low copy,
  // then take the lowest set bit; the upper copy provides the wrap-around.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < 2 * NREQ; i++) begin
      masked[i] = dbl[i] & ((i >= NREQ) || (i >= int'(ptr)));
    end
    for (int i = 0; i < 2 * NREQ; i++) begin
      if (masked[i] && !found) begin
        found  = 1'b1;
        winner = OWNER_W'(i % NREQ);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
// Latency: first write 1 cycle after req from idle; 0-cycle handover between owners.
// Backpressure: full stalls the owner (count and owner hold, no timeout).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int M        = 7,
  parameter int MAXBURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*(M+1)-1:0] din_all,
  input  logic                  full,
  output logic                  w_en,
  output logic [M:0]            din,
  output logic [NREQ-1:0]       gnt,
  output logic [OWNER_W-1:0]    owner,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(MAXBURST);

  state_t             state, state_nxt;
  logic [OWNER_W-1:0] owner_q, owner_nxt;
  logic [OWNER_W-1:0] ptr_q, ptr_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [OWNER_W-1:0] next_after;
  logic [OWNER_W-1:0] pick_ptr;
  logic               pick_any;
  logic [OWNER_W-1:0] pick_winner;
  logic               owner_req;
  logic [M:0]         owner_dat;
  logic [NREQ-1:0]    owner_onehot;
  logic               burst_end;

  // Pointer one past the current owner, wrapping at NREQ.
  assign next_after = (owner_q == OWNER_W'(NREQ - 1)) ? '0 : owner_q + OWNER_W'(1);

  // In BURST the search must already start after the owner so the handover
  // decision is ready in the same cycle as the burst end.
  assign pick_ptr = (state == BURST) ? next_after : ptr_q;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .any    (pick_any),
    .winner (pick_winner)
  );

  // Select the owner's request bit, data slice and one-hot grant pattern.
  always_comb begin
    owner_req    = 1'b0;
    owner_dat    = '0;
    owner_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == OWNER_W'(i)) begin
        owner_req       = req[i];
        owner_dat       = din_all[i*(M+1) +: (M+1)];
        owner_onehot[i] = 1'b1;
      end
    end
  end

  // State register; reset aborts any burst and restarts priority at requester 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      owner_q <= owner_nxt;
      ptr_q   <= ptr_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Next-state and write-port outputs.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner_q;
    ptr_nxt   = ptr_q;
    cnt_nxt   = cnt_q;
    w_en      = 1'b0;
    burst_end = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = BURST;
          owner_nxt = pick_winner;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        w_en = owner_req & ~full;
        if (w_en) cnt_nxt = cnt_q + CNT_W'(1);
        // A stalled write at the boundary does not count, so the burst lives on.
        burst_end = (w_en && (cnt_q == CNT_W'(MAXBURST - 1))) || !owner_req;
        if (burst_end) begin
          ptr_nxt = next_after;
          cnt_nxt = '0;
          if (pick_any) begin
            owner_nxt = pick_winner;
          end else begin
            state_nxt = IDLE;
            owner_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    din  = w_en ? owner_dat : '0;
    gnt  = w_en ? owner_onehot : '0;
  end

  assign owner = owner_q;
  assign busy  = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a 4-requester instance under directed
// and random traffic, plus a 2-requester single-word-burst instance.
// Expected responses are queued per cycle and checked by a separate monitor.
module tb_fifo_wr_arbiter;

  localparam int NR   = 4;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-requester instance
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din_all;
  logic        full;
  logic        w_en;
  logic [7:0]  din;
  logic [3:0]  gnt;
  logic [2:0]  owner;
  logic        busy;

  // 2-requester, MAXBURST=1 instance
  logic        rst2;
  logic [1:0]  req2;
  logic [15:0] din_all2;
  logic        full2;
  logic        w_en2;
  logic [7:0]  din2;
  logic [1:0]  gnt2;
  logic [2:0]  owner2;
  logic        busy2;

  fifo_wr_arbiter #(.NREQ(4), .M(7), .MAXBURST(4)) dut (
    .clk(clk), .reset(rst_n), .req(req), .din_all(din_all), .full(full),
    .w_en(w_en), .din(din), .gnt(gnt), .owner(owner), .busy(busy)
  );

  fifo_wr_arbiter #(.NREQ(2), .M(7), .MAXBURST(1)) dut2 (
    .clk(clk), .reset(rst2), .req(req2), .din_all(din_all2), .full(full2),
    .w_en(w_en2), .din(din2), .gnt(gnt2), .owner(owner2), .busy(busy2)
  );

  typedef struct packed {
    logic       w_en;
    logic [7:0] din;
    logic [3:0] gnt;
    logic [2:0] owner;
    logic       busy;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: is someone owning the port, who, how many words
  // so far, and where the next round-robin search begins.
  bit m_busy;
  int m_owner, m_cnt, m_ptr;

  function automatic int rr_from(input logic [3:0] r, input int from);
    for (int k = 0; k < NR; k++) begin
      if (r[(from + k) % NR]) return (from + k) % NR;
    end
    return -1;
  endfunction

  // One clock of the behavioural model: emit this cycle's expected outputs,
  // then advance to what the next edge should leave behind.
  task automatic model_step();
    exp_t e;
    int   w;
    bit   wr;
    e = '0;
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    end else if (!m_busy) begin
      w = rr_from(req, m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_cnt = 0;
      end
    end else begin
      wr      = req[m_owner] && !full;
      e.busy  = 1'b1;
      e.owner = 3'(m_owner);
      if (wr) begin
        e.w_en = 1'b1;
        e.din  = din_all[m_owner*8 +: 8];
        e.gnt  = 4'(1 << m_owner);
        m_cnt++;
      end
      if ((wr && m_cnt == MAXB) || !req[m_owner]) begin
        m_ptr = (m_owner + 1) % NR;
        w = rr_from(req, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_cnt = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
    q1.push_back(e);
  endtask

  task automatic cycle(input logic r, input logic [3:0] rq, input logic f, input logic [31:0] d);
    @(negedge clk);
    rst_n   = r;
    req     = rq;
    full    = f;
    din_all = d;
    model_step();
  endtask

  task automatic cycle2(input logic r, input int k);
    exp_t e;
    @(negedge clk);
    rst2 = r;
    req2 = r ? 2'b11 : 2'b00;
    e = '0;
    // k counts cycles since release: cycle 0 arbitrates, then owners alternate.
    if (r && k > 0) begin
      e.w_en  = 1'b1;
      e.busy  = 1'b1;
      e.owner = (k % 2 == 1) ? 3'd0 : 3'd1;
      e.gnt   = (k % 2 == 1) ? 4'b0001 : 4'b0010;
      e.din   = (k % 2 == 1) ? 8'h11 : 8'h22;
    end
    q2.push_back(e);
  endtask

  task automatic check(input exp_t e, input logic a_w, input logic [7:0] a_d,
                       input logic [3:0] a_g, input logic [2:0] a_o, input logic a_b,
                       input string name);
    bit bad;
    vectors++;
    bad = (a_w !== e.w_en) || (a_d !== e.din) || (a_g !== e.gnt) ||
          (a_b !== e.busy) || (e.busy && (a_o !== e.owner));
    if (bad) begin
      miscompares++;
      $display("FAIL %s t=%0t: got w_en=%b din=%h gnt=%b owner=%0d busy=%b, want w_en=%b din=%h gnt=%b owner=%0d busy=%b",
               name, $time, a_w, a_d, a_g, a_o, a_b, e.w_en, e.din, e.gnt, e.owner, e.busy);
    end
  endtask

  // Monitor: just after each negedge the DUT outputs have settled on the
  // inputs driven at that edge; compare against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check(e, w_en, din, gnt, owner, busy, "arb4");
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check(e, w_en2, din2, {2'b00, gnt2}, owner2, busy2, "arb2_mb1");
      end
    end
  end

  initial begin
    logic [3:0] rq;
    logic       f;
    logic       r;
    rst_n = 1'b0; req = '0; full = 1'b0; din_all = '0;
    rst2 = 1'b0; req2 = '0; full2 = 1'b0; din_all2 = 16'h2211;

    // All four requesting through reset, then release: 4 words each in order.
    repeat (2) cycle(1'b0, 4'hF, 1'b0, $urandom);
    repeat (18) cycle(1'b1, 4'hF, 1'b0, $urandom);

    // Lone requester 2: write 1 cycle after req, back-to-back bursts.
    cycle(1'b0, 4'h0, 1'b0, 32'h0);
    repeat (12) cycle(1'b1, 4'b0100, 1'b0, 32'h00A5_0000);

    // Owner 1 stalled by full after 2 writes, then finishes the burst.
    cycle(1'b0, 4'h0, 1'b0, 32'h0);
    repeat (3) cycle(1'b1, 4'b0010, 1'b0, $urandom);
    repeat (3) cycle(1'b1, 4'b0010, 1'b1, $urandom);
    repeat (6) cycle(1'b1, 4'b0010, 1'b0, $urandom);

    // Owner 0 drops after one write while requester 3 waits.
    cycle(1'b0, 4'h0, 1'b0, 32'h0);
    repeat (2) cycle(1'b1, 4'b1001, 1'b0, $urandom);
    repeat (8) cycle(1'b1, 4'b1000, 1'b0, $urandom);

    // Reset mid-burst (two words written): outputs must drop at once.
    cycle(1'b0, 4'h0, 1'b0, 32'h0);
    repeat (3) cycle(1'b1, 4'hF, 1'b0, $urandom);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (w_en !== 1'b0 || gnt !== 4'b0 || busy !== 1'b0 || owner !== 3'd0 || din !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: got w_en=%b gnt=%b busy=%b owner=%0d din=%h, want all zero",
               w_en, gnt, busy, owner, din);
    end
    cycle(1'b0, 4'hF, 1'b0, $urandom);
    repeat (8) cycle(1'b1, 4'hF, 1'b0, $urandom);

    // Random traffic: sticky requests, intermittent full, rare resets.
    rq = 4'h0;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(5) == 0) rq[b] = ~rq[b];
      end
      f = ($urandom_range(3) == 0);
      r = ($urandom_range(199) != 0);
      cycle(r, rq, f, $urandom);
    end

    // Two requesters, single-word bursts: grant alternates every cycle.
    repeat (2) cycle2(1'b0, 0);
    for (int k = 0; k < 12; k++) cycle2(1'b1, k);

    repeat (3) @(negedge clk);
    #2;
    if (q1.size() != 0 || q2.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d and %0d expectations left unchecked, want 0", q1.size(), q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
